// File: rtl/mod_sub_serial_if.sv
// rtl/mod_sub_serial_if.sv - start/done handshake and operand/result bus of the bit-serial subtractor
interface mod_sub_serial_if #(
  parameter int width = 4
);
  logic             start;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [width-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/mod_sub_serial.sv
// rtl/mod_sub_serial.sv - bit-serial a - b - bin, LSB first, one borrow FF; MOD_SUB_OVF_EN adds signed overflow
module mod_sub_serial #(
  parameter int width = 4
) (
  input  logic                clk,
  input  logic                rst,
  mod_sub_serial_if.slave     bus
);
  localparam int cw = $clog2(width) + 1;
  localparam logic [cw-1:0] last_cnt = cw'(width - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [width-1:0] a_sh;
  logic [width-1:0] b_sh;
  logic [width-1:0] diff_q;
  logic             brw;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic [cw-1:0]    cnt;
  logic             d;
  logic             brw_next;
  logic             accept;
  logic             last_bit;

  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ brw;
    brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
    accept   = (state == IDLE) && bus.start;
    last_bit = (state == SHIFT) && (cnt == last_cnt);
  end

  // diff_q doubles as the result shift register; it is only meaningful once done fires
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_q <= '0;
      brw    <= 1'b0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            brw    <= bus.bin;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          diff_q <= {d, diff_q[width-1:1]};
          brw    <= brw_next;
          cnt    <= cnt + cw'(1);
          if (cnt == last_cnt) begin
            bout_q <= brw_next;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef MOD_SUB_OVF_EN
  logic ovf_q;

  // On the last bit a_sh[0]/b_sh[0] hold the captured sign bits and d is the result sign
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= (a_sh[0] != b_sh[0]) && (d != a_sh[0]);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_mod_sub_serial.sv
// tb/tb_mod_sub_serial.sv - scoreboard bench for mod_sub_serial against an integer-arithmetic model
module tb_mod_sub_serial;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  exp_t sb_q[$];

  mod_sub_serial_if #(.width(W)) bus ();

  mod_sub_serial #(.width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic exp_t model(input int a, input int b, input int bin);
    exp_t e;
    int   r;
    int   sa;
    int   sb;
    int   sr;
    r      = a - b - bin;
    e.diff = W'(r & ((1 << W) - 1));
    e.bout = (a < b + bin);
    sa     = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb     = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sr     = sa - sb - bin;
`ifdef MOD_SUB_OVF_EN
    e.ovf  = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
`else
    e.ovf  = 1'b0;
    if (sr == 0) e.ovf = 1'b0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      check("pending_ops", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("diff", 32'(bus.diff), 32'(e.diff));
        check("bout", 32'(bus.bout), 32'(e.bout));
        check("ovf",  32'(bus.ovf),  32'(e.ovf));
      end
    end
  end

  task automatic run_op(input int a, input int b, input int bin, input bit glitch);
    exp_t e;
    int   busy_cycles;
    e = model(a, b, bin);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.bin   = bin[0];
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    check("clear_on_accept", {29'd0, bus.diff == '0, bus.bout, bus.ovf}, 32'b100);
    busy_cycles = 0;
    for (int i = 0; i < W; i++) begin
      if (bus.busy && !bus.done) busy_cycles++;
      if (glitch && i == 1) begin
        bus.start = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("busy_width", 32'(busy_cycles), 32'(W));
    check("done_latency", {30'd0, bus.done, bus.busy}, 32'b10);
    bus.start = glitch;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("done_one_cycle", {30'd0, bus.done, bus.busy}, 32'b00);
    repeat (2) @(posedge clk);
    #1;
    check("hold", {26'd0, bus.diff, bus.bout, bus.ovf}, {26'd0, e.diff, e.bout, e.ovf});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {25'd0, bus.busy, bus.done, bus.diff, bus.bout, bus.ovf}, 32'd0);
    rst = 1'b0;

    run_op(7, 3, 0, 1'b0);
    run_op(3, 7, 0, 1'b0);
    run_op(0, 0, 1, 1'b0);
    run_op(8, 1, 0, 1'b1);
    run_op(7, 15, 0, 1'b0);
    run_op(8, 0, 1, 1'b0);
    run_op(15, 15, 1, 1'b1);

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = W'(9);
    bus.b     = W'(2);
    bus.bin   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_state", {25'd0, bus.busy, bus.done, bus.diff, bus.bout, bus.ovf}, 32'd0);
    seen = 1'b0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op(5, 1, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      run_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 1)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mod_sub_serial.md
Name: mod_sub_serial

Overview:
- Bit-serial subtractor: computes diff = a - b - bin one bit per clock, LSB first, using a single borrow flip-flop.
- Counterpart of the combinational ripple-carry adder (`mod_sum`). Trades latency for area.
- Sits in the control-unit datapath where a subtract/compare result is needed and multi-cycle latency is acceptable.
- Start/done handshake toward the control FSM.

Parameters:
- width, 4, operand and result width in bits (>= 2).

Ports:
- clk    input   1      system clock, rising edge.
- rst    input   1      synchronous, active-high reset.
- start  input   1      request; sampled only in IDLE.
- a      input   width  minuend; captured on accepted start.
- b      input   width  subtrahend; captured on accepted start.
- bin    input   1      borrow-in; captured on accepted start.
- busy   output  1      high while the operation is in progress (SHIFT state).
- done   output  1      one-cycle pulse: result valid.
- diff   output  width  result a - b - bin, modulo 2^width.
- bout   output  1      final borrow out; 1 when the unsigned a < b + bin.
- ovf    output  1      signed overflow (see Optional Feature).

Behaviour:
- Reset:
  - Sampled on the rising clk edge while rst=1.
  - Forces state=IDLE and clears busy, done, diff, bout, ovf, the internal shift registers, the borrow FF and the bit counter.
  - rst has priority over every other input.
  - Reset mid-operation aborts the operation. No done pulse follows; outputs read 0 on the next cycle.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, capture a, b and bin into a_sh, b_sh and the borrow FF. Clear cnt. Go to SHIFT.
  - On start=0, stay in IDLE. diff and bout hold their last values.
- SHIFT (busy=1), per cycle:
  - d = a_sh[0] ^ b_sh[0] ^ brw.
  - brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - Shift a_sh and b_sh right by one.
  - Shift d into the result register from the MSB side.
  - cnt increments by 1.
  - When cnt == width-1, this is the last bit: go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0.
  - diff = the full result register; bout = the final borrow FF.
  - Then returns to IDLE.
- Latency:
  - Start is accepted at edge k.
  - SHIFT occupies edges k+1 .. k+width.
  - done is high for the cycle following edge k+width.
  - Total: width+1 cycles from start to done.
- Back-to-back operation:
  - start asserted while in DONE is ignored.
  - A new start is accepted in IDLE, earliest on the cycle after done.
- start while busy=1 is ignored.
  - Operands changing during SHIFT do not affect the result, because they were captured at start.
- Result stability: diff, bout and ovf stay stable from done until the next accepted start. They are cleared to 0 on accept.
- Wrap-around: the result is always modulo 2^width; no saturation.
- cnt width is $clog2(width)+1 bits, so the counter never wraps inside an operation.

Optional Feature:
- Macro: MOD_SUB_OVF_EN.
- Defined:
  - ovf is computed at the last SHIFT bit as (a_msb != b_msb) && (d != a_msb), using the captured MSBs of a and b.
  - It is registered with diff and is valid while done=1.
  - It holds its value the same way diff does.
- Undefined:
  - ovf is tied to 0.
  - No extra registers are inferred.
  - The port still exists, so the instance interface does not change.

Test Plan:
- Basic subtract: width=4, a=0111, b=0011, bin=0, start pulse → busy for 4 cycles, done on the 5th cycle after the start edge; diff=0100, bout=0.
- Negative result: a=0011, b=0111, bin=0 → diff=1100, bout=1; ovf=0 with MOD_SUB_OVF_EN defined.
- Borrow-in only: a=0000, b=0000, bin=1 → diff=1111, bout=1.
- Start while busy: start a=1000, b=0001; pulse start with a=0000, b=0000 two cycles later → that second start is ignored; done once with diff=0111, bout=0.
- Reset mid-operation: assert rst on the 2nd SHIFT cycle for one cycle → no done pulse; busy=0, diff=0000, bout=0 the next cycle. A following start computes 0101-0001 → diff=0100.
- Overflow (MOD_SUB_OVF_EN defined): a=0111, b=1111 → diff=1000, bout=1, ovf=1. Same stimulus without the macro → ovf=0.
